// File: rtl/reg_bank_reader.sv
// Register bank with an extension register and a one-slot request/response read port.
// Read operands are captured at acceptance, with write-through bypass from the same-cycle write.
module reg_bank_reader #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              ext_write,
    input  logic [DATA_W-1:0] wr_data_ext,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] ext_data
);

    localparam int NREG = 1 << ADDR_W;

    typedef enum logic {
        S_EMPTY,
        S_FULL
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_regs [NREG];
    logic [DATA_W-1:0] r_ext;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_ext_data;

    logic              w_accept;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic [DATA_W-1:0] w_ext_val;

    assign req_ready = (r_state == S_EMPTY) || rsp_ready;
    assign w_accept  = req_valid && req_ready;
    assign rsp_valid = (r_state == S_FULL);
    assign rs_data   = r_rs_data;
    assign rt_data   = r_rt_data;
    assign ext_data  = r_ext_data;

    // Writes to register 0 are dropped when it is hardwired to zero.
    assign w_wr_en = reg_write && !((ZERO_REG != 0) && (wr_addr == '0));

    always_comb begin
        w_rs_val = r_regs[rs_addr];
        if ((ZERO_REG != 0) && (rs_addr == '0)) begin
            w_rs_val = '0;
        end else if (reg_write && (wr_addr == rs_addr)) begin
            w_rs_val = wr_data;
        end
    end

    always_comb begin
        w_rt_val = r_regs[rt_addr];
        if ((ZERO_REG != 0) && (rt_addr == '0)) begin
            w_rt_val = '0;
        end else if (reg_write && (wr_addr == rt_addr)) begin
            w_rt_val = wr_data;
        end
    end

    assign w_ext_val = ext_write ? wr_data_ext : r_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_ext <= '0;
        end else begin
            if (w_wr_en) begin
                r_regs[wr_addr] <= wr_data;
            end
            if (ext_write) begin
                r_ext <= wr_data_ext;
            end
        end
    end

    // Response slot: a held response is a snapshot and ignores later writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_ext_data <= '0;
        end else begin
            if (w_accept) begin
                r_rs_data  <= w_rs_val;
                r_rt_data  <= w_rt_val;
                r_ext_data <= w_ext_val;
            end
            case (r_state)
                S_EMPTY: if (w_accept) r_state <= S_FULL;
                S_FULL:  if (rsp_ready && !req_valid) r_state <= S_EMPTY;
                default: r_state <= S_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_reader.sv
// Directed bench for reg_bank_reader: reset, read latency, bypass, zero register,
// backpressure snapshot, back-to-back responses and asynchronous reset.
module tb_reg_bank_reader;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic          reg_write;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          ext_write;
    logic [DW-1:0] wr_data_ext;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] ext_data;

    int n_tests = 0;
    int n_fail  = 0;

    reg_bank_reader #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .ZERO_REG(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_write  (reg_write),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .ext_write  (ext_write),
        .wr_data_ext(wr_data_ext),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .ext_data   (ext_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        reg_write   = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        ext_write   = 1'b0;
        wr_data_ext = '0;
        req_valid   = 1'b0;
        rs_addr     = '0;
        rt_addr     = '0;
        rsp_ready   = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #2;
        n_tests++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        n_tests++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0 || ext_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_data got %h %h %h exp 0 0 0", rs_data, rt_data, ext_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_first_read();
        @(negedge clk);
        req_valid = 1'b1; rs_addr = 5'd5; rt_addr = 5'd31;
        step();
        n_tests++;
        if (rsp_valid !== 1'b1 || rs_data !== 32'h0 || rt_data !== 32'h0 || ext_data !== 32'h0) begin
            n_fail++; $display("FAIL first_read got v=%b %h %h %h exp v=1 0 0 0", rsp_valid, rs_data, rt_data, ext_data);
        end
        @(negedge clk);
        idle_inputs();
        step();
        n_tests++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL drain_to_empty got %b exp 0", rsp_valid); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        reg_write = 1'b1; wr_addr = 5'd31; wr_data = 32'h0000_0040;
        @(negedge clk);
        wr_addr = 5'd20; wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        idle_inputs();
        req_valid = 1'b1; rs_addr = 5'd20; rt_addr = 5'd31;
        step();
        n_tests++;
        if (rsp_valid !== 1'b1 || rs_data !== 32'hDEAD_BEEF || rt_data !== 32'h0000_0040) begin
            n_fail++; $display("FAIL write_read got v=%b %h %h exp v=1 deadbeef 00000040", rsp_valid, rs_data, rt_data);
        end
        @(negedge clk);
        idle_inputs();
        step();
    endtask

    task automatic test_bypass();
        @(negedge clk);
        reg_write = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_1234;
        ext_write = 1'b1; wr_data_ext = 32'hFFFF_0000;
        req_valid = 1'b1; rs_addr = 5'd7; rt_addr = 5'd7;
        step();
        n_tests++;
        if (rs_data !== 32'h0000_1234 || ext_data !== 32'hFFFF_0000) begin
            n_fail++; $display("FAIL bypass got %h %h exp 00001234 ffff0000", rs_data, ext_data);
        end
        n_tests++;
        if (rt_data !== 32'h0000_1234) begin
            n_fail++; $display("FAIL same_addr got rt=%h exp 00001234", rt_data);
        end
        @(negedge clk);
        idle_inputs();
        req_valid = 1'b1; rs_addr = 5'd20; rt_addr = 5'd7;
        step();
        n_tests++;
        if (rs_data !== 32'hDEAD_BEEF || rt_data !== 32'h0000_1234 || ext_data !== 32'hFFFF_0000) begin
            n_fail++; $display("FAIL stored_after_bypass got %h %h %h exp deadbeef 00001234 ffff0000", rs_data, rt_data, ext_data);
        end
        @(negedge clk);
        idle_inputs();
        step();
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        reg_write = 1'b1; wr_addr = 5'd0; wr_data = 32'hAAAA_AAAA;
        req_valid = 1'b1; rs_addr = 5'd0; rt_addr = 5'd20;
        step();
        n_tests++;
        if (rs_data !== 32'h0 || rt_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL zero_bypass got %h %h exp 0 deadbeef", rs_data, rt_data);
        end
        @(negedge clk);
        idle_inputs();
        req_valid = 1'b1; rs_addr = 5'd31; rt_addr = 5'd0;
        step();
        n_tests++;
        if (rs_data !== 32'h0000_0040 || rt_data !== 32'h0) begin
            n_fail++; $display("FAIL zero_later got %h %h exp 00000040 0", rs_data, rt_data);
        end
        @(negedge clk);
        idle_inputs();
        step();
    endtask

    task automatic test_hold_back_to_back();
        logic [DW-1:0] wvals [3];
        wvals[0] = 32'h0000_0055;
        wvals[1] = 32'h0000_0066;
        wvals[2] = 32'h0000_0077;
        @(negedge clk);
        req_valid = 1'b1; rs_addr = 5'd20; rt_addr = 5'd31;
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rsp_ready = 1'b0;
            req_valid = 1'b1; rs_addr = 5'd20; rt_addr = 5'd31;
            reg_write = 1'b1; wr_addr = 5'd20; wr_data = wvals[i];
            #1;
            n_tests++;
            if (req_ready !== 1'b0) begin n_fail++; $display("FAIL hold_req_ready cyc=%0d got %b exp 0", i, req_ready); end
            step();
            n_tests++;
            if (rsp_valid !== 1'b1 || rs_data !== 32'hDEAD_BEEF || rt_data !== 32'h0000_0040) begin
                n_fail++; $display("FAIL hold_stable cyc=%0d got v=%b %h %h exp v=1 deadbeef 00000040", i, rsp_valid, rs_data, rt_data);
            end
        end
        @(negedge clk);
        idle_inputs();
        req_valid = 1'b1; rs_addr = 5'd20; rt_addr = 5'd31;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL release_req_ready got %b exp 1", req_ready); end
        step();
        n_tests++;
        if (rsp_valid !== 1'b1 || rs_data !== 32'h0000_0077 || rt_data !== 32'h0000_0040) begin
            n_fail++; $display("FAIL reload got v=%b %h %h exp v=1 00000077 00000040", rsp_valid, rs_data, rt_data);
        end
        @(negedge clk);
        req_valid = 1'b1; rs_addr = 5'd31; rt_addr = 5'd20;
        reg_write = 1'b1; wr_addr = 5'd31; wr_data = 32'h0000_0099;
        step();
        n_tests++;
        if (rsp_valid !== 1'b1 || rs_data !== 32'h0000_0099 || rt_data !== 32'h0000_0077) begin
            n_fail++; $display("FAIL back_to_back got v=%b %h %h exp v=1 00000099 00000077", rsp_valid, rs_data, rt_data);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        idle_inputs();
        rsp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0 || rs_data !== 32'h0 || rt_data !== 32'h0 || ext_data !== 32'h0) begin
            n_fail++; $display("FAIL async_reset got v=%b %h %h %h exp v=0 0 0 0", rsp_valid, rs_data, rt_data, ext_data);
        end
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        idle_inputs();
        req_valid = 1'b1; rs_addr = 5'd20; rt_addr = 5'd31;
        step();
        n_tests++;
        if (rsp_valid !== 1'b1 || rs_data !== 32'h0 || rt_data !== 32'h0 || ext_data !== 32'h0) begin
            n_fail++; $display("FAIL post_reset_read got v=%b %h %h %h exp v=1 0 0 0", rsp_valid, rs_data, rt_data, ext_data);
        end
        @(negedge clk);
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_hold_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
